// File: rtl/dec_trigger_ctr.sv
// Decode-stage execute triggers: exact/NAPOT PC match, pair chaining,
// hit-count qualification (DEC_TRIGGER_COUNT_EN), sticky status.
// Ports: clk, rst_l; trig_* trigger config from TLU CSRs;
//   lane_valid/lane_pc/lane_flush decode lanes; hit_clr sticky clear;
//   trigger_match_q[l*NUM_TRIG+i] registered fire, hit_sticky, count_q.
module dec_trigger_ctr #(
  parameter int NUM_TRIG  = 4,
  parameter int NUM_LANES = 2,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic [NUM_TRIG-1:0]        trig_execute,
  input  logic [NUM_TRIG-1:0]        trig_m,
  input  logic [NUM_TRIG-1:0]        trig_select,
  input  logic [NUM_TRIG-1:0]        trig_match,
  input  logic [NUM_TRIG-1:0]        trig_chain,
  input  logic [NUM_TRIG*32-1:0]     trig_tdata2,
  input  logic [NUM_TRIG-1:0]        trig_cfg_wen,
  input  logic [CNT_W-1:0]           trig_cfg_count,
  input  logic [NUM_LANES-1:0]       lane_valid,
  input  logic [NUM_LANES*31-1:0]    lane_pc,
  input  logic                       lane_flush,
  input  logic [NUM_TRIG-1:0]        hit_clr,
  output logic [NUM_LANES*NUM_TRIG-1:0] trigger_match_q,
  output logic [NUM_TRIG-1:0]        hit_sticky,
  output logic [NUM_TRIG*CNT_W-1:0]  count_q
);

  typedef logic [NUM_LANES-1:0][NUM_TRIG-1:0] lt_t;

  logic [NUM_TRIG-1:0][31:0] care;
  logic                      ones;
  logic [31:0]               cv;
  logic [31:0]               td;
  lt_t                       raw;
  lt_t                       qual;
  lt_t                       fire;
  lt_t                       match_q;
  logic [NUM_TRIG-1:0]       sticky_q;
  logic [NUM_TRIG-1:0]       sticky_d;

  // Bit k is don't-care in mask mode when tdata2[k-1:0] are all ones.
  always_comb begin
    care = '0;
    ones = 1'b1;
    for (int i = 0; i < NUM_TRIG; i++) begin
      ones = 1'b1;
      care[i][0] = 1'b0;
      for (int k = 1; k < 32; k++) begin
        ones = ones & trig_tdata2[32*i+k-1];
        care[i][k] = ~(trig_match[i] & ones);
      end
    end
  end

  always_comb begin
    raw = '0;
    cv  = '0;
    td  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int i = 0; i < NUM_TRIG; i++) begin
        td = trig_tdata2[32*i +: 32];
        cv = {lane_pc[31*l +: 31], td[0]};
        raw[l][i] = lane_valid[l] & trig_execute[i]
                  & trig_m[i] & ~trig_select[i]
                  & ~lane_flush
                  & ~|((cv ^ td) & care[i]);
      end
    end
  end

  // Only even-indexed chain bits pair a trigger with its successor.
  always_comb begin
    qual = raw;
    for (int i = 0; i + 1 < NUM_TRIG; i += 2) begin
      if (trig_chain[i]) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          qual[l][i]   = raw[l][i] & raw[l][i+1];
          qual[l][i+1] = raw[l][i] & raw[l][i+1];
        end
      end
    end
  end

`ifdef DEC_TRIGGER_COUNT_EN
  logic [NUM_TRIG-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_TRIG-1:0][CNT_W-1:0] cnt_d;
  logic                           hit;
  logic                           found;

  always_comb begin
    cnt_d = cnt_q;
    fire  = '0;
    hit   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      hit   = 1'b0;
      found = 1'b0;
      for (int l = 0; l < NUM_LANES; l++)
        hit = hit | qual[l][i];
      if (trig_cfg_wen[i]) begin
        cnt_d[i] = trig_cfg_count;
      end else if (cnt_q[i] == '0) begin
        for (int l = 0; l < NUM_LANES; l++)
          fire[l][i] = qual[l][i];
      end else if (hit) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
        // Last count: release only the oldest hitting lane.
        if (cnt_q[i] == CNT_W'(1)) begin
          for (int l = 0; l < NUM_LANES; l++) begin
            if (qual[l][i] && !found) begin
              fire[l][i] = 1'b1;
              found = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_q = cnt_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{trig_cfg_wen, trig_cfg_count};
  assign fire       = qual;
  assign count_q    = '0;
`endif

  always_comb begin
    sticky_d = sticky_q & ~hit_clr;
    for (int i = 0; i < NUM_TRIG; i++)
      for (int l = 0; l < NUM_LANES; l++)
        if (fire[l][i]) sticky_d[i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      match_q  <= '0;
      sticky_q <= '0;
    end else begin
      match_q  <= fire;
      sticky_q <= sticky_d;
    end
  end

  assign trigger_match_q = match_q;
  assign hit_sticky      = sticky_q;

endmodule

// File: tb/tb_dec_trigger_ctr.sv
// Testbench for dec_trigger_ctr: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_dec_trigger_ctr;
  localparam int NT = 4;
  localparam int NL = 2;
  localparam int CW = 8;
`ifdef DEC_TRIGGER_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic [NT-1:0]    trig_execute, trig_m, trig_select;
  logic [NT-1:0]    trig_match, trig_chain, trig_cfg_wen;
  logic [NT*32-1:0] trig_tdata2;
  logic [CW-1:0]    trig_cfg_count;
  logic [NL-1:0]    lane_valid;
  logic [NL*31-1:0] lane_pc;
  logic             lane_flush;
  logic [NT-1:0]    hit_clr;
  logic [NL*NT-1:0] trigger_match_q;
  logic [NT-1:0]    hit_sticky;
  logic [NT*CW-1:0] count_q;

  dec_trigger_ctr #(.NUM_TRIG(NT), .NUM_LANES(NL), .CNT_W(CW)) dut (
    .clk(clk), .rst_l(rst_l),
    .trig_execute(trig_execute), .trig_m(trig_m),
    .trig_select(trig_select), .trig_match(trig_match),
    .trig_chain(trig_chain), .trig_tdata2(trig_tdata2),
    .trig_cfg_wen(trig_cfg_wen), .trig_cfg_count(trig_cfg_count),
    .lane_valid(lane_valid), .lane_pc(lane_pc),
    .lane_flush(lane_flush), .hit_clr(hit_clr),
    .trigger_match_q(trigger_match_q), .hit_sticky(hit_sticky),
    .count_q(count_q)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;

  int               mcnt[NT];
  bit               mstk[NT];
  logic [NL*NT-1:0] mmatch;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit cmp_ok(int i, int l);
    logic [31:0] td;
    logic [31:0] pc32;
    int t;
    td   = trig_tdata2[32*i +: 32];
    pc32 = {lane_pc[31*l +: 31], td[0]};
    if (!trig_match[i]) return pc32 == td;
    t = 0;
    while (t < 32 && td[t]) t++;
    // Everything at or below the first zero of tdata2 is ignored.
    return (64'(pc32) >> (t + 1)) == (64'(td) >> (t + 1));
  endfunction

  task automatic model_step();
    bit r[NL][NT];
    bit q[NL][NT];
    bit f[NL][NT];
    for (int l = 0; l < NL; l++)
      for (int i = 0; i < NT; i++) begin
        r[l][i] = lane_valid[l] && trig_execute[i] && trig_m[i]
                  && !trig_select[i] && !lane_flush && cmp_ok(i, l);
        q[l][i] = r[l][i];
        f[l][i] = 1'b0;
      end
    for (int i = 0; i + 1 < NT; i += 2)
      if (trig_chain[i])
        for (int l = 0; l < NL; l++) begin
          q[l][i]   = r[l][i] && r[l][i+1];
          q[l][i+1] = q[l][i];
        end
    for (int i = 0; i < NT; i++) begin
      int first;
      bit any;
      first = -1;
      for (int l = NL - 1; l >= 0; l--)
        if (q[l][i]) first = l;
      if (!CNT_EN) begin
        for (int l = 0; l < NL; l++) f[l][i] = q[l][i];
      end else if (trig_cfg_wen[i]) begin
        mcnt[i] = int'(trig_cfg_count);
      end else if (mcnt[i] == 0) begin
        for (int l = 0; l < NL; l++) f[l][i] = q[l][i];
      end else if (first >= 0) begin
        if (mcnt[i] == 1) f[first][i] = 1'b1;
        mcnt[i] = mcnt[i] - 1;
      end
      any = 1'b0;
      for (int l = 0; l < NL; l++) begin
        mmatch[l*NT+i] = f[l][i];
        if (f[l][i]) any = 1'b1;
      end
      if (any) mstk[i] = 1'b1;
      else if (hit_clr[i]) mstk[i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      mcnt[i] = 0;
      mstk[i] = 1'b0;
    end
    mmatch = '0;
  endtask

  task automatic cyc();
    logic [NT-1:0]    es;
    logic [NT*CW-1:0] ec;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NT; i++) begin
      es[i] = mstk[i];
      ec[i*CW +: CW] = mcnt[i][CW-1:0];
    end
    chk("match", 64'(trigger_match_q), 64'(mmatch));
    chk("sticky", 64'(hit_sticky), 64'(es));
    chk("count", 64'(count_q), 64'(ec));
    @(negedge clk);
  endtask

  task automatic idle();
    trig_execute   = '0;
    trig_m         = '0;
    trig_select    = '0;
    trig_match     = '0;
    trig_chain     = '0;
    trig_tdata2    = '0;
    trig_cfg_wen   = '0;
    trig_cfg_count = '0;
    lane_valid     = '0;
    lane_pc        = '0;
    lane_flush     = 1'b0;
    hit_clr        = '0;
  endtask

  task automatic set_pc(int l, logic [31:0] pc);
    lane_pc[31*l +: 31] = pc[31:1];
  endtask

  function automatic logic [31:0] pick_td();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_1000;
      1:       return 32'h0000_20FF;
      2:       return 32'h0000_1004;
      3:       return 32'h0000_3FFF;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    idle();
    model_reset();
    #12;
    chk("rst_match", 64'(trigger_match_q), 64'h0);
    chk("rst_sticky", 64'(hit_sticky), 64'h0);
    chk("rst_count", 64'(count_q), 64'h0);
    @(negedge clk);
    rst_l = 1'b1;

    // Exact match on trigger 0, lane 0
    trig_execute[0] = 1'b1;
    trig_m[0] = 1'b1;
    trig_tdata2[31:0] = 32'h0000_1000;
    lane_valid = 2'b01;
    set_pc(0, 32'h0000_1000);
    cyc();
    chk("exact_hit", 64'(trigger_match_q[0]), 64'h1);
    set_pc(0, 32'h0000_1002);
    cyc();
    chk("exact_miss", 64'(trigger_match_q[0]), 64'h0);

    // NAPOT window 0x2000..0x21FF
    trig_tdata2[31:0] = 32'h0000_20FF;
    trig_match[0] = 1'b1;
    for (int a = 32'h2000; a <= 32'h21FE; a += 2) begin
      set_pc(0, 32'(a));
      cyc();
    end
    chk("napot_last", 64'(trigger_match_q[0]), 64'h1);
    set_pc(0, 32'h0000_2200);
    cyc();
    chk("napot_out", 64'(trigger_match_q[0]), 64'h0);

    // Chain pair 0/1
    idle();
    trig_execute[1:0] = 2'b11;
    trig_m[1:0] = 2'b11;
    trig_chain[0] = 1'b1;
    trig_tdata2[31:0] = 32'h0000_1000;
    trig_tdata2[63:32] = 32'h0000_1000;
    lane_valid = 2'b01;
    set_pc(0, 32'h0000_1000);
    cyc();
    chk("chain_both", 64'(trigger_match_q[1:0]), 64'h3);
    trig_tdata2[63:32] = 32'h0000_1004;
    cyc();
    chk("chain_none", 64'(trigger_match_q[1:0]), 64'h0);

    // Flush, then hit_clr colliding with a fire
    trig_chain = '0;
    lane_flush = 1'b1;
    cyc();
    chk("flush", 64'(trigger_match_q), 64'h0);
    lane_flush = 1'b0;
    hit_clr[0] = 1'b1;
    cyc();
    chk("clr_vs_set", 64'(hit_sticky[0]), 64'h1);
    hit_clr[0] = 1'b0;

    // Counter qualification with both lanes hitting
    idle();
    trig_execute[0] = 1'b1;
    trig_m[0] = 1'b1;
    trig_tdata2[31:0] = 32'h0000_1000;
    lane_valid = 2'b11;
    set_pc(0, 32'h0000_1000);
    set_pc(1, 32'h0000_1000);
    trig_cfg_wen[0] = 1'b1;
    trig_cfg_count = 8'd3;
    cyc();
    trig_cfg_wen[0] = 1'b0;
    for (int c = 0; c < 4; c++) cyc();
    if (CNT_EN) begin
      chk("cnt_after", 64'(count_q[CW-1:0]), 64'h0);
    end
    chk("cnt_both", 64'({trigger_match_q[NT], trigger_match_q[0]}), 64'h3);
    lane_flush = 1'b1;
    cyc();
    lane_flush = 1'b0;

    // Async reset with count and sticky live
    trig_cfg_wen[0] = 1'b1;
    trig_cfg_count = 8'd2;
    cyc();
    trig_cfg_wen[0] = 1'b0;
    #2;
    rst_l = 1'b0;
    #1;
    chk("arst_match", 64'(trigger_match_q), 64'h0);
    chk("arst_sticky", 64'(hit_sticky), 64'h0);
    chk("arst_count", 64'(count_q), 64'h0);
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;

    // Randomized traffic
    idle();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NT; i++)
        trig_tdata2[32*i +: 32] = pick_td();
      trig_execute = 4'($urandom_range(0, 15) | 4'h5);
      trig_m       = 4'($urandom_range(0, 15) | 4'h3);
      trig_select  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      trig_match   = 4'($urandom);
      trig_chain   = 4'($urandom);
      trig_cfg_wen = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      trig_cfg_count = 8'($urandom_range(0, 3));
      lane_valid   = 2'($urandom_range(0, 3));
      lane_flush   = ($urandom_range(0, 9) == 0);
      hit_clr      = 4'($urandom);
      for (int l = 0; l < NL; l++) begin
        logic [31:0] p;
        p = trig_tdata2[32*$urandom_range(0, NT-1) +: 32];
        if ($urandom_range(0, 2) == 0)
          p = p ^ (32'h1 << $urandom_range(1, 12));
        set_pc(l, p);
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
